// File: rtl/bot_event_latch.sv
// rtl/bot_event_latch.sv - multi-channel event latch with sync, ack, mask, priority ID and overrun
// Each channel: synchroniser -> edge/level detect -> pending flag held until acknowledged.
module bot_event_latch #(
  parameter int NUM_CH      = 4,
  parameter int CH_ID_W     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic               clk50,
  input  logic               resetn,
  input  logic [NUM_CH-1:0]  IO_BotUpdt,
  input  logic [NUM_CH-1:0]  IO_INT_ACK,
  input  logic [NUM_CH-1:0]  IO_INT_MASK,
  input  logic [NUM_CH-1:0]  IO_OVR_CLR,
  output logic [NUM_CH-1:0]  IO_BotUpdt_Sync,
  output logic               IO_INT_REQ,
  output logic [CH_ID_W-1:0] IO_INT_ID,
  output logic [NUM_CH-1:0]  IO_Overrun
);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [SYNC_STAGES-1:0]             fill_q;
  logic [NUM_CH-1:0]                  armed_q;
  logic [NUM_CH-1:0]                  sync_s;
  logic [NUM_CH-1:0]                  ev;
  logic [NUM_CH-1:0]                  req_vec;
  logic [NUM_CH-1:0]                  pend_d;
  logic [NUM_CH-1:0]                  ovr_d;

  // fill_q tracks how many stages hold real samples since reset release
  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], IO_BotUpdt};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // A channel only arms once a genuine low has been seen, so a line still
  // high across reset release cannot fake an event.
  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      armed_q <= '0;
    end else begin
      armed_q <= armed_q | ({NUM_CH{fill_q[SYNC_STAGES-1]}} & ~sync_s);
    end
  end

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [NUM_CH-1:0] hist_q;

      always_ff @(posedge clk50 or negedge resetn) begin
        if (!resetn) begin
          hist_q <= '0;
        end else begin
          hist_q <= sync_s;
        end
      end

      assign ev = sync_s & ~hist_q & armed_q;
    end else begin : g_level
      assign ev = sync_s & armed_q;
    end
  endgenerate

  // A new event wins over an ack in the same cycle, so nothing is lost.
  assign pend_d = ev | (IO_BotUpdt_Sync & ~IO_INT_ACK);
  assign ovr_d  = (ev & IO_BotUpdt_Sync & ~IO_INT_ACK) | (IO_Overrun & ~IO_OVR_CLR);

  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      IO_BotUpdt_Sync <= '0;
      IO_Overrun      <= '0;
    end else begin
      IO_BotUpdt_Sync <= pend_d;
      IO_Overrun      <= ovr_d;
    end
  end

  assign req_vec    = IO_BotUpdt_Sync & IO_INT_MASK;
  assign IO_INT_REQ = |req_vec;

  // Scan downward so the lowest pending index is the last one written.
  always_comb begin
    IO_INT_ID = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        IO_INT_ID = CH_ID_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_bot_event_latch.sv
// tb/tb_bot_event_latch.sv - table-driven scoreboard bench for bot_event_latch
// Covers edge-mode and level-mode instances sharing the same stimulus.
module tb_bot_event_latch;

  typedef struct {
    logic [3:0] bt;
    logic [3:0] ack;
    logic [3:0] mask;
    logic [3:0] clr;
    logic [3:0] sync;
    logic       req;
    logic [1:0] id;
    logic [3:0] ovr;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] sync;
    logic       req;
    logic [1:0] id;
    logic [3:0] ovr;
  } exp_t;

  logic       clk50 = 1'b0;
  logic       resetn;
  logic [3:0] bt, ack, mask, clr;
  logic       chk_lvl;

  logic [3:0] e_sync, e_ovr, l_sync, l_ovr;
  logic       e_req, l_req;
  logic [1:0] e_id, l_id;

  logic [3:0] o_sync, o_ovr;
  logic       o_req;
  logic [1:0] o_id;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];
  exp_t exp_q[$];

  always #10 clk50 = ~clk50;

  bot_event_latch #(.NUM_CH(4), .CH_ID_W(2), .SYNC_STAGES(2), .EDGE_MODE(1)) dut_edge (
    .clk50(clk50), .resetn(resetn), .IO_BotUpdt(bt), .IO_INT_ACK(ack),
    .IO_INT_MASK(mask), .IO_OVR_CLR(clr), .IO_BotUpdt_Sync(e_sync),
    .IO_INT_REQ(e_req), .IO_INT_ID(e_id), .IO_Overrun(e_ovr)
  );

  bot_event_latch #(.NUM_CH(4), .CH_ID_W(2), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_lvl (
    .clk50(clk50), .resetn(resetn), .IO_BotUpdt(bt), .IO_INT_ACK(ack),
    .IO_INT_MASK(mask), .IO_OVR_CLR(clr), .IO_BotUpdt_Sync(l_sync),
    .IO_INT_REQ(l_req), .IO_INT_ID(l_id), .IO_Overrun(l_ovr)
  );

  assign o_sync = chk_lvl ? l_sync : e_sync;
  assign o_req  = chk_lvl ? l_req  : e_req;
  assign o_id   = chk_lvl ? l_id   : e_id;
  assign o_ovr  = chk_lvl ? l_ovr  : e_ovr;

  task automatic compare_head();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue, want an expectation");
    end else begin
      e = exp_q.pop_front();
      if (o_sync !== e.sync || o_req !== e.req || o_id !== e.id || o_ovr !== e.ovr) begin
        errors++;
        $display("FAIL %s: got sync=%b req=%b id=%0d ovr=%b, want sync=%b req=%b id=%0d ovr=%b",
                 e.tag, o_sync, o_req, o_id, o_ovr, e.sync, e.req, e.id, e.ovr);
      end
    end
  endtask

  task automatic push_exp(input string tag, input logic [3:0] sync, input logic req,
                          input logic [1:0] id, input logic [3:0] ovr);
    exp_t e;
    e.tag = tag; e.sync = sync; e.req = req; e.id = id; e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic [3:0] sync, input logic req,
                           input logic [1:0] id, input logic [3:0] ovr);
    push_exp(tag, sync, req, id, ovr);
    compare_head();
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk50);
    bt = v.bt; ack = v.ack; mask = v.mask; clr = v.clr;
    push_exp(tag, v.sync, v.req, v.id, v.ovr);
    @(posedge clk50);
    #1;
    compare_head();
  endtask

  task automatic add(input logic [3:0] vbt, input logic [3:0] vack, input logic [3:0] vmask,
                     input logic [3:0] vclr, input logic [3:0] vsync, input logic vreq,
                     input logic [1:0] vid, input logic [3:0] vovr);
    vec_t v;
    v.bt = vbt; v.ack = vack; v.mask = vmask; v.clr = vclr;
    v.sync = vsync; v.req = vreq; v.id = vid; v.ovr = vovr;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; bt = '0; ack = '0; mask = 4'hF; clr = '0; chk_lvl = 1'b0;
    #35;
    check_now("reset_edge", 4'h0, 1'b0, 2'd0, 4'h0);
    chk_lvl = 1'b1;
    check_now("reset_lvl", 4'h0, 1'b0, 2'd0, 4'h0);
    chk_lvl = 1'b0;
    @(negedge clk50);
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) add(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    run_tbl("idle");

    // single pulse on ch2, 2-edge latency, one latch only
    add(4'h4, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h4, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h4, 4'h0, 4'hF, 4'h0, 4'h4, 1'b1, 2'd2, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h4, 1'b1, 2'd2, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h4, 1'b1, 2'd2, 4'h0);
    add(4'h0, 4'h4, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    run_tbl("pulse");

    // ch1 and ch3 pending under partial mask
    add(4'hA, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'h8, 4'h0, 4'hA, 1'b1, 2'd3, 4'h0);
    add(4'h0, 4'h8, 4'h8, 4'h0, 4'h2, 1'b0, 2'd0, 4'h0);
    run_tbl("mask");
    @(negedge clk50);
    ack = 4'h0;
    mask = 4'hF;
    #1;
    check_now("unmask_comb", 4'h2, 1'b1, 2'd1, 4'h0);
    add(4'h0, 4'h2, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    run_tbl("mask_clean");

    // overrun on ch0, clear, and set coinciding with clear
    add(4'h1, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h1, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h1);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h1);
    add(4'h0, 4'h0, 4'hF, 4'h1, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h1, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h1, 4'h1, 1'b1, 2'd0, 4'h1);
    add(4'h0, 4'h0, 4'hF, 4'h1, 4'h1, 1'b1, 2'd0, 4'h0);
    run_tbl("ovr");

    // ack coinciding with a new event keeps pending, no overrun
    add(4'h1, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h1, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h1, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    run_tbl("ack_ev");

    // all pending plus overrun, then input held high into reset
    add(4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 2'd0, 4'h0);
    add(4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 2'd0, 4'hF);
    for (int i = 0; i < 3; i++) add(4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 2'd0, 4'hF);
    run_tbl("pre_rst");
    @(posedge clk50);
    #3;
    resetn = 1'b0;
    #1;
    check_now("async_rst", 4'h0, 1'b0, 2'd0, 4'h0);
    @(negedge clk50);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) add(4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 2; i++) add(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 2; i++) add(4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 2'd0, 4'h0);
    add(4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    run_tbl("post_rst");

    // level-mode instance
    @(negedge clk50);
    resetn = 1'b0; bt = '0; ack = '0; clr = '0; mask = 4'hF;
    chk_lvl = 1'b1;
    #1;
    check_now("lvl_rst", 4'h0, 1'b0, 2'd0, 4'h0);
    @(negedge clk50);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) add(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 2; i++) add(4'h2, 4'h2, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 3; i++) add(4'h2, 4'h2, 4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 4'h0);
    for (int i = 0; i < 2; i++) add(4'h0, 4'h2, 4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 4'h0);
    add(4'h0, 4'h2, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 2; i++) add(4'h2, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 4'h0);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 4'h2);
    add(4'h0, 4'h0, 4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 4'h2);
    run_tbl("level");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bot_event_latch.md
Name: bot_event_latch

Overview:
- Multi-channel successor to the single-bit BotUpdt handshake flip-flop.
- Synchronises NUM_CH asynchronous update/event lines into the clk50 domain and latches each event as a pending flag that stays set until firmware acknowledges it over the AHB-lite I/O interface.
- Adds per-channel rising-edge or level detection, interrupt masking, a priority-encoded interrupt ID and sticky overrun flags, so that a missed handshake is visible to software.

Parameters:
- NUM_CH, 4: number of event channels (1..16).
- CH_ID_W, 2: width of IO_INT_ID; must satisfy 2^CH_ID_W >= NUM_CH.
- SYNC_STAGES, 2: synchroniser flops per channel (2..4).
- EDGE_MODE, 1: 1 = event on rising edge of synchronised input; 0 = event every cycle the synchronised input is high (level).

Ports:
- clk50  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- IO_BotUpdt  input  NUM_CH  raw event lines; asynchronous to clk50.
- IO_INT_ACK  input  NUM_CH  per-channel acknowledge pulses; synchronous to clk50.
- IO_INT_MASK  input  NUM_CH  1 = channel may raise IO_INT_REQ; does not gate latching.
- IO_OVR_CLR  input  NUM_CH  per-channel overrun clear; synchronous to clk50.
- IO_BotUpdt_Sync  output  NUM_CH  pending flags, registered.
- IO_INT_REQ  output  1  OR of (pending AND mask), combinational from registers.
- IO_INT_ID  output  CH_ID_W  index of the lowest-numbered unmasked pending channel; 0 when none.
- IO_Overrun  output  NUM_CH  sticky overrun flags, registered.

Behaviour:
- Reset: while resetn = 0, all synchroniser stages, edge-history regs, IO_BotUpdt_Sync and IO_Overrun are forced to 0 immediately (asynchronously).
  - As a result, IO_INT_REQ = 0 and IO_INT_ID = 0 during reset.
  - Deassertion mid-event: no event is generated until a fresh rising edge has passed through the synchroniser.
- Synchroniser: each channel has a SYNC_STAGES-deep shift chain. s = last stage.
- Event detect:
  - EDGE_MODE=1: a history reg h tracks s (h <= s each cycle). ev = s & ~h.
  - EDGE_MODE=0: ev = s.
- Latency, EDGE_MODE=1: input high before edge k -> stage1 set at edge k -> s high after edge k+SYNC_STAGES-1 -> pending set at edge k+SYNC_STAGES. For SYNC_STAGES=2, pending rises at the 2nd clk50 edge after the input is first sampled high.
- Pending update, per channel, evaluated each cycle in this priority order:
  1. ev=1: pending <= 1. If the channel was already pending with no ack this cycle, the event is merged; see the overrun rule.
  2. ack=1, ev=0: pending <= 0.
  3. Otherwise: hold.
  - Simultaneous ack and event: the ack retires the old event and the new event re-sets pending. Pending stays 1, no overrun, no event lost.
  - Ack with pending=0: no effect, no error.
- Overrun update, per channel:
  - Sets to 1 when ev=1 & pending=1 & ack=0.
  - Cleared by IO_OVR_CLR=1.
  - If set and clear coincide, set wins.
  - Overrun never affects pending or request.
- Level mode: a held-high input re-asserts pending every cycle. An ack takes effect only after the input drops. With no ack, overrun sets on the 2nd high cycle.
- Mask: masked channels still latch and report overrun. Unmasking a pending channel raises IO_INT_REQ in the same cycle (combinational).
- IO_INT_ID: priority to the lowest index. Updates combinationally with pending/mask. Channels >= NUM_CH do not exist.
- Channels are fully independent. Multi-bit ack/clear words act on every set bit in the same cycle.

Test Plan (NUM_CH=4, SYNC_STAGES=2, EDGE_MODE=1 unless stated):
- Reset, then pulse IO_BotUpdt[2] high for 3 cycles with mask=4'hF -> IO_BotUpdt_Sync=4'b0100 exactly 2 edges after first sample; IO_INT_REQ=1; IO_INT_ID=2; a single latch only, no overrun.
- Channels 1 and 3 pending, mask=4'b1000 -> IO_INT_ID=3; ack[3] -> REQ=0, ID=0, Sync=4'b0010; then mask=4'hF -> REQ=1, ID=1 in the same cycle.
- Second rising edge on ch0 while pending, no ack -> IO_Overrun[0]=1 and stays 1. IO_OVR_CLR[0] -> 0 next edge. A new set coincident with clear -> remains 1.
- ack[0] in the exact cycle ch0's new event is detected -> IO_BotUpdt_Sync[0] stays 1, IO_Overrun[0]=0.
- Assert resetn=0 asynchronously mid-pulse with pending=4'hF and overrun set -> all outputs 0 before the next clk50 edge. After release with the input still high, no new event is generated until the input toggles low then high.
- EDGE_MODE=0: hold ch1 high 5 cycles, ack every cycle -> pending stays 1 throughout, no overrun. Drop the input, ack once -> pending=0. Hold high 2 cycles without ack -> IO_Overrun[1]=1.
